// File: rtl/spi_flash_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_reader_pkg
// Description : Shared types and op codes for the SPI flash word reader.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_flash_reader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_ON,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_CS_OFF,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_ISSUE,
        PH_GAP,
        PH_POLL,
        PH_FETCH
    } phase_t;

    // c_op_fetch at the sequencer boundary means SEND + POLL + FETCH
    localparam logic [2:0] c_op_cs_on  = 3'd0;
    localparam logic [2:0] c_op_cs_off = 3'd1;
    localparam logic [2:0] c_op_send   = 3'd2;
    localparam logic [2:0] c_op_poll   = 3'd3;
    localparam logic [2:0] c_op_fetch  = 3'd4;

    localparam logic [3:0] c_wstrb_byte = 4'b0001;
    localparam logic [3:0] c_wstrb_none = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/spi_access_seq.sv
`default_nettype none
// ============================================================================
// Module      : spi_access_seq
// Description : Runs one primitive op against the SPI master register port,
//               including the valid/ready handshake, idle gap and busy poll.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_access_seq
    import spi_flash_reader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  tx_byte,
    output logic        done,
    output logic [7:0]  rx_byte,
    output logic        spi_valid,
    output logic        spi_ctrl,
    output logic [31:0] spi_wdata,
    output logic [3:0]  spi_wstrb,
    input  logic [31:0] spi_rdata,
    input  logic        spi_ready
);

    phase_t r_phase;
    phase_t r_next;
    logic   r_send;
    logic   r_fetch;
    logic   w_unused_rdata;

    assign w_unused_rdata = ^spi_rdata[30:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase   <= PH_IDLE;
            r_next    <= PH_IDLE;
            r_send    <= 1'b0;
            r_fetch   <= 1'b0;
            done      <= 1'b0;
            rx_byte   <= 8'h00;
            spi_valid <= 1'b0;
            spi_ctrl  <= 1'b0;
            spi_wdata <= 32'h0;
            spi_wstrb <= c_wstrb_none;
        end else begin
            done <= 1'b0;
            case (r_phase)
                PH_IDLE: begin
                    if (start) begin
                        spi_valid <= 1'b1;
                        spi_wstrb <= c_wstrb_byte;
                        r_phase   <= PH_ISSUE;
                        r_send    <= (op == c_op_send) || (op == c_op_fetch);
                        r_fetch   <= (op == c_op_fetch);
                        if ((op == c_op_cs_on) || (op == c_op_cs_off)) begin
                            spi_ctrl  <= 1'b0;
                            spi_wdata <= {31'h0, (op == c_op_cs_on)};
                        end else begin
                            spi_ctrl  <= 1'b1;
                            spi_wdata <= {24'h0, tx_byte};
                        end
                    end
                end
                PH_ISSUE: begin
                    if (spi_ready) begin
                        spi_valid <= 1'b0;
                        if (r_send) begin
                            r_phase <= PH_GAP;
                            r_next  <= PH_POLL;
                        end else begin
                            done    <= 1'b1;
                            r_phase <= PH_IDLE;
                        end
                    end
                end
                // valid was dropped on the acknowledge edge; re-raise it here
                PH_GAP: begin
                    spi_valid <= 1'b1;
                    spi_ctrl  <= (r_next == PH_FETCH);
                    spi_wdata <= 32'h0;
                    spi_wstrb <= c_wstrb_none;
                    r_phase   <= r_next;
                end
                PH_POLL: begin
                    if (spi_ready) begin
                        spi_valid <= 1'b0;
                        if (spi_rdata[31]) begin
                            r_phase <= PH_GAP;
                            r_next  <= PH_POLL;
                        end else if (r_fetch) begin
                            r_phase <= PH_GAP;
                            r_next  <= PH_FETCH;
                        end else begin
                            done    <= 1'b1;
                            r_phase <= PH_IDLE;
                        end
                    end
                end
                PH_FETCH: begin
                    if (spi_ready) begin
                        spi_valid <= 1'b0;
                        rx_byte   <= spi_rdata[7:0];
                        done      <= 1'b1;
                        r_phase   <= PH_IDLE;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_reader
// Description : Turns a 32-bit CPU read into a SPI NOR read transaction, with
//               a one-entry last-word cache.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter logic [7:0] CMD         = 8'h03,
    parameter int         DUMMY_BYTES = 0,
    parameter bit         CACHE_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid,
    input  logic [23:0] addr,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        spi_valid,
    output logic        spi_ctrl,
    output logic [31:0] spi_wdata,
    output logic [3:0]  spi_wstrb,
    input  logic [31:0] spi_rdata,
    input  logic        spi_ready
);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_start;
    logic [21:0] r_word_addr;
    logic [21:0] r_tag;
    logic [31:0] r_cache_data;
    logic        r_cache_valid;
    logic [2:0]  w_op;
    logic [7:0]  w_tx;
    logic        w_done;
    logic [7:0]  w_rx;
    logic        w_hit;
    logic        w_unused_addr;

    assign w_unused_addr = ^addr[1:0];
    assign w_hit = CACHE_EN && r_cache_valid && !flush && (addr[23:2] == r_tag);

    // Op for the current state; the sequencer latches it on r_start
    always_comb begin
        w_op = c_op_send;
        w_tx = 8'h00;
        case (r_state)
            ST_CS_ON:  w_op = c_op_cs_on;
            ST_CS_OFF: w_op = c_op_cs_off;
            ST_CMD:    w_tx = CMD;
            ST_ADDR: begin
                case (r_cnt)
                    2'd0:    w_tx = r_word_addr[21:14];
                    2'd1:    w_tx = r_word_addr[13:6];
                    default: w_tx = {r_word_addr[5:0], 2'b00};
                endcase
            end
            ST_DATA:   w_op = c_op_fetch;
            default:   ;
        endcase
    end

    spi_access_seq u_seq (
        .clk       (clk),
        .reset     (reset),
        .start     (r_start),
        .op        (w_op),
        .tx_byte   (w_tx),
        .done      (w_done),
        .rx_byte   (w_rx),
        .spi_valid (spi_valid),
        .spi_ctrl  (spi_ctrl),
        .spi_wdata (spi_wdata),
        .spi_wstrb (spi_wstrb),
        .spi_rdata (spi_rdata),
        .spi_ready (spi_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 2'd0;
            r_start       <= 1'b0;
            r_word_addr   <= 22'h0;
            r_tag         <= 22'h0;
            r_cache_data  <= 32'h0;
            r_cache_valid <= 1'b0;
            ready         <= 1'b0;
            rdata         <= 32'h0;
            busy          <= 1'b0;
        end else begin
            r_start <= 1'b0;
            ready   <= 1'b0;
            if (flush) begin
                r_cache_valid <= 1'b0;
            end
            case (r_state)
                // !ready: the CPU still holds valid during the ready cycle
                ST_IDLE: begin
                    if (valid && !ready) begin
                        if (w_hit) begin
                            ready <= 1'b1;
                            rdata <= r_cache_data;
                        end else begin
                            r_word_addr <= addr[23:2];
                            busy        <= 1'b1;
                            r_start     <= 1'b1;
                            r_state     <= ST_CS_ON;
                        end
                    end
                end
                ST_CS_ON: begin
                    if (w_done) begin
                        r_start <= 1'b1;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_done) begin
                        r_cnt   <= 2'd0;
                        r_start <= 1'b1;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_done) begin
                        r_start <= 1'b1;
                        if (r_cnt == 2'd2) begin
                            r_cnt   <= 2'd0;
                            r_state <= (DUMMY_BYTES != 0) ? ST_DUMMY : ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (w_done) begin
                        r_cnt   <= 2'd0;
                        r_start <= 1'b1;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_done) begin
                        rdata[{r_cnt, 3'b000} +: 8] <= w_rx;
                        r_cnt   <= r_cnt + 2'd1;
                        r_start <= 1'b1;
                        if (r_cnt == 2'd3) begin
                            r_state <= ST_CS_OFF;
                        end
                    end
                end
                ST_CS_OFF: begin
                    if (w_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready         <= 1'b1;
                    busy          <= 1'b0;
                    r_tag         <= r_word_addr;
                    r_cache_data  <= rdata;
                    r_cache_valid <= !flush;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_reader
// Description : Bench for spi_flash_reader with an SPI master + flash model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;
    import spi_flash_reader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush[2];
    logic        valid[2];
    logic [23:0] addr[2];
    logic        ready[2];
    logic [31:0] rdata[2];
    logic        busy[2];
    logic        spi_valid[2];
    logic        spi_ctrl[2];
    logic [31:0] spi_wdata[2];
    logic [3:0]  spi_wstrb[2];
    logic [31:0] spi_rdata[2];
    logic        spi_ready[2];

    spi_flash_reader #(.CMD(8'h03), .DUMMY_BYTES(0), .CACHE_EN(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush[0]), .valid(valid[0]), .addr(addr[0]),
        .ready(ready[0]), .rdata(rdata[0]), .busy(busy[0]),
        .spi_valid(spi_valid[0]), .spi_ctrl(spi_ctrl[0]), .spi_wdata(spi_wdata[0]),
        .spi_wstrb(spi_wstrb[0]), .spi_rdata(spi_rdata[0]), .spi_ready(spi_ready[0])
    );

    spi_flash_reader #(.CMD(8'h0B), .DUMMY_BYTES(1), .CACHE_EN(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush[1]), .valid(valid[1]), .addr(addr[1]),
        .ready(ready[1]), .rdata(rdata[1]), .busy(busy[1]),
        .spi_valid(spi_valid[1]), .spi_ctrl(spi_ctrl[1]), .spi_wdata(spi_wdata[1]),
        .spi_wstrb(spi_wstrb[1]), .spi_rdata(spi_rdata[1]), .spi_ready(spi_ready[1])
    );

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000104: return 8'h11;
            24'h000105: return 8'h22;
            24'h000106: return 8'h33;
            24'h000107: return 8'h44;
            24'h000202: return 8'hFF;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    // SPI master + flash model; instance i uses i dummy bytes
    int          n_vpulse[2] = '{0, 0};
    int          n_cs_on[2]  = '{0, 0};
    int          n_cs_off[2] = '{0, 0};
    int          n_viol[2]   = '{0, 0};
    int          n_fetch[2]  = '{0, 0};
    int          n_ready[2]  = '{0, 0};
    int          n_busy[2]   = '{0, 0};
    int          poll_busy   = 2;
    logic        cs_low[2];
    int          busy_left[2];
    int          wait_cnt[2];
    logic        acked[2];
    logic        prev_valid[2];
    logic [7:0]  rx[2];
    logic [23:0] m_addr[2];
    logic [7:0]  sent[2][16];
    int          nsent[2];
    logic        held_ctrl[2];
    logic [31:0] held_wdata[2];
    logic [3:0]  held_wstrb[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                spi_ready[i]  <= 1'b0;
                spi_rdata[i]  <= 32'h0;
                cs_low[i]     <= 1'b0;
                busy_left[i]  <= 0;
                wait_cnt[i]   <= 0;
                acked[i]      <= 1'b0;
                prev_valid[i] <= 1'b0;
                rx[i]         <= 8'h00;
                m_addr[i]     <= 24'h0;
                nsent[i]      <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                prev_valid[i] <= spi_valid[i];
                acked[i]      <= 1'b0;
                if (spi_valid[i] && !prev_valid[i]) begin
                    n_vpulse[i]   <= n_vpulse[i] + 1;
                    held_ctrl[i]  <= spi_ctrl[i];
                    held_wdata[i] <= spi_wdata[i];
                    held_wstrb[i] <= spi_wstrb[i];
                end
                if (spi_valid[i] && (acked[i] || (prev_valid[i] &&
                    ({held_ctrl[i], held_wdata[i], held_wstrb[i]} !==
                     {spi_ctrl[i], spi_wdata[i], spi_wstrb[i]}))))
                    n_viol[i] <= n_viol[i] + 1;
                if (spi_ready[i]) begin
                    spi_ready[i] <= 1'b0;
                    acked[i]     <= 1'b1;
                end else if (spi_valid[i]) begin
                    if (wait_cnt[i] == 0) begin
                        wait_cnt[i] <= 1;
                    end else begin
                        wait_cnt[i]  <= 0;
                        spi_ready[i] <= 1'b1;
                        if (!spi_ctrl[i] && spi_wstrb[i] == 4'b0001) begin
                            spi_rdata[i] <= 32'h0;
                            if (spi_wdata[i][0]) begin
                                cs_low[i]  <= 1'b1;
                                n_cs_on[i] <= n_cs_on[i] + 1;
                                nsent[i]   <= 0;
                            end else begin
                                cs_low[i]   <= 1'b0;
                                n_cs_off[i] <= n_cs_off[i] + 1;
                            end
                        end else if (spi_ctrl[i] && spi_wstrb[i] == 4'b0001) begin
                            spi_rdata[i] <= 32'h0;
                            if (!cs_low[i]) n_viol[i] <= n_viol[i] + 1;
                            if (nsent[i] < 16) sent[i][nsent[i]] <= spi_wdata[i][7:0];
                            nsent[i]     <= nsent[i] + 1;
                            busy_left[i] <= poll_busy;
                            case (nsent[i])
                                1: m_addr[i][23:16] <= spi_wdata[i][7:0];
                                2: m_addr[i][15:8]  <= spi_wdata[i][7:0];
                                3: m_addr[i][7:0]   <= spi_wdata[i][7:0];
                                default: ;
                            endcase
                            if (nsent[i] >= 4 + i)
                                rx[i] <= flash_byte(m_addr[i] + 24'(nsent[i] - 4 - i));
                            else
                                rx[i] <= 8'hEE;
                        end else if (!spi_ctrl[i]) begin
                            if (!cs_low[i]) n_viol[i] <= n_viol[i] + 1;
                            spi_rdata[i] <= {(busy_left[i] != 0), 23'h0, rx[i]};
                            if (busy_left[i] != 0) busy_left[i] <= busy_left[i] - 1;
                        end else begin
                            if (!cs_low[i] || busy_left[i] != 0) n_viol[i] <= n_viol[i] + 1;
                            spi_rdata[i] <= {24'h0, rx[i]};
                            n_fetch[i]   <= n_fetch[i] + 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ready[i]) n_ready[i] <= n_ready[i] + 1;
            if (busy[i])  n_busy[i]  <= n_busy[i] + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_read(input int d, input logic [23:0] a,
                           output logic [31:0] data, output int lat);
        lat      = 0;
        valid[d] = 1'b1;
        addr[d]  = a;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready[d] && lat < 5000);
        data     = rdata[d];
        if (!ready[d]) check("read timeout", 32'd0, 32'd1);
        valid[d] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        int          d;
        logic        flush;
        logic [23:0] addr;
        logic        hit;
        int          polls;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          d, lat, cyc, ne, nerr;
        int          vp0, con0, coff0, viol0, rd0, fet0, bsy0;
        logic [31:0] data;
        logic [7:0]  eb[16];
        logic [23:0] a;

        vecs[0] = '{0, 1'b0, 24'h000104, 1'b0, 2,  32'h44332211};
        vecs[1] = '{0, 1'b0, 24'h000106, 1'b1, 2,  32'h44332211};
        vecs[2] = '{0, 1'b1, 24'h000104, 1'b0, 2,  32'h44332211};
        vecs[3] = '{0, 1'b0, 24'h000200, 1'b0, 20, 32'h5BFF5958};
        vecs[4] = '{0, 1'b0, 24'h000203, 1'b1, 2,  32'h5BFF5958};
        vecs[5] = '{1, 1'b0, 24'hA2A1A0, 1'b0, 2,  32'hFAFBF8F9};
        vecs[6] = '{1, 1'b0, 24'hA2A1A3, 1'b1, 2,  32'hFAFBF8F9};
        vecs[7] = '{1, 1'b0, 24'h000104, 1'b0, 20, 32'h44332211};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            flush[i] = 1'b0;
            valid[i] = 1'b0;
            addr[i]  = 24'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset rdata%0d", i), rdata[i], 32'h0);
            check($sformatf("reset ctl%0d", i),
                  {26'h0, ready[i], busy[i], spi_valid[i], spi_ctrl[i], 2'b00}, 32'h0);
            check($sformatf("reset spi%0d", i), spi_wdata[i] | {28'h0, spi_wstrb[i]}, 32'h0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            d         = vecs[k].d;
            a         = vecs[k].addr;
            poll_busy = vecs[k].polls;
            if (vecs[k].flush) begin
                flush[d] = 1'b1;
                @(negedge clk);
                flush[d] = 1'b0;
                @(negedge clk);
            end
            vp0 = n_vpulse[d]; con0 = n_cs_on[d]; coff0 = n_cs_off[d];
            viol0 = n_viol[d]; rd0 = n_ready[d]; fet0 = n_fetch[d]; bsy0 = n_busy[d];
            do_read(d, a, data, lat);
            check($sformatf("v%0d rdata", k), data, vecs[k].exp);
            check($sformatf("v%0d ready pulses", k), 32'(n_ready[d] - rd0), 32'd1);
            check($sformatf("v%0d spi protocol errors", k), 32'(n_viol[d] - viol0), 32'd0);
            if (vecs[k].hit) begin
                check($sformatf("v%0d hit latency", k), 32'(lat), 32'd1);
                check($sformatf("v%0d hit spi_valid pulses", k), 32'(n_vpulse[d] - vp0), 32'd0);
                check($sformatf("v%0d hit busy cycles", k), 32'(n_busy[d] - bsy0), 32'd0);
            end else begin
                check($sformatf("v%0d cs_on count", k), 32'(n_cs_on[d] - con0), 32'd1);
                check($sformatf("v%0d cs_off count", k), 32'(n_cs_off[d] - coff0), 32'd1);
                check($sformatf("v%0d fetch count", k), 32'(n_fetch[d] - fet0), 32'd4);
                ne = 0;
                eb[0] = (d == 1) ? 8'h0B : 8'h03;
                eb[1] = a[23:16];
                eb[2] = a[15:8];
                eb[3] = {a[7:2], 2'b00};
                ne = 4;
                if (d == 1) begin
                    eb[4] = 8'h00;
                    ne = 5;
                end
                for (int j = 0; j < 4; j++) eb[ne + j] = 8'h00;
                ne = ne + 4;
                check($sformatf("v%0d bytes sent", k), 32'(nsent[d]), 32'(ne));
                nerr = 0;
                for (int j = 0; j < ne; j++) if (sent[d][j] !== eb[j]) nerr++;
                check($sformatf("v%0d byte sequence errors", k), 32'(nerr), 32'd0);
            end
        end

        // flush landing in the same cycle as DONE: word returned, entry left invalid
        poll_busy = 2;
        valid[0]  = 1'b1;
        addr[0]   = 24'h000400;
        cyc       = 0;
        while (u_dut0.r_state != ST_DONE && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        check("flush@done ready", {31'h0, ready[0]}, 32'd1);
        check("flush@done rdata", rdata[0], 32'h5D5C5F5E);
        valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        vp0 = n_vpulse[0];
        do_read(0, 24'h000400, data, lat);
        check("flush@done refetch rdata", data, 32'h5D5C5F5E);
        check("flush@done refetch is miss", {31'h0, n_vpulse[0] != vp0}, 32'd1);

        // reset during the address phase
        valid[0] = 1'b1;
        addr[0]  = 24'h000300;
        con0     = n_cs_on[0];
        cyc      = 0;
        while ((n_cs_on[0] == con0 || nsent[0] < 2) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("addr phase reached", {31'h0, u_dut0.r_state == ST_ADDR}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset rdata", rdata[0], 32'h0);
        check("midreset ctl", {27'h0, ready[0], busy[0], spi_valid[0], spi_ctrl[0], 1'b0}, 32'h0);
        check("midreset spi", spi_wdata[0] | {28'h0, spi_wstrb[0]}, 32'h0);
        valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vp0 = n_vpulse[0]; con0 = n_cs_on[0]; viol0 = n_viol[0];
        do_read(0, 24'h000400, data, lat);
        check("postreset rdata", data, 32'h5D5C5F5E);
        check("postreset cache invalid", {31'h0, n_vpulse[0] != vp0}, 32'd1);
        check("postreset cs_on count", 32'(n_cs_on[0] - con0), 32'd1);
        check("postreset first byte", {24'h0, sent[0][0]}, 32'h03);
        check("postreset spi protocol errors", 32'(n_viol[0] - viol0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
